// File: rtl/led_pattern_monitor.sv
// Receive-side checker for the one-hot LED sequence 001 -> 010 -> 100 -> 000.
// Locks onto the sequence, then flags and counts sequence errors and completed cycles.
module led_pattern_monitor #(
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 8,
   parameter int CYC_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic [2:0]       led_in,
   input  logic             clr,
   output logic             locked,
   output logic [1:0]       phase,
   output logic             err_pulse,
   output logic             invalid,
   output logic [ERR_W-1:0] err_cnt,
   output logic [CYC_W-1:0] cyc_cnt,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_ACQ    = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;
   localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);

   logic [1:0] state, state_nx;
   logic [1:0] exp_idx, exp_nx;
   logic [3:0] match_cnt, match_nx;
   logic [1:0] idx, succ;
   logic       legal, hit, err_evt, cyc_evt;

   always_comb begin
      legal = 1'b1;
      idx   = 2'd0;
      case (led_in)
         3'b001:  idx = 2'd0;
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         3'b000:  idx = 2'd3;
         default: legal = 1'b0;
      endcase
   end

   assign succ = idx + 2'd1;
   assign hit  = legal && (idx == exp_idx);

   // A miss outside SEARCH re-anchors on a legal sample, or drops to SEARCH on an illegal one.
   always_comb begin
      state_nx = state;
      exp_nx   = exp_idx;
      match_nx = match_cnt;
      err_evt  = 1'b0;
      cyc_evt  = 1'b0;
      if (sample_en) begin
         case (state)
            S_ACQ, S_LOCKED: begin
               if (hit) begin
                  exp_nx = succ;
                  if (state == S_LOCKED) begin
                     cyc_evt = (idx == 2'd0);
                  end else begin
                     match_nx = match_cnt + 4'd1;
                     if (match_cnt + 4'd1 >= LOCK_N) state_nx = S_LOCKED;
                  end
               end else begin
                  err_evt = (state == S_LOCKED);
                  if (legal) begin
                     exp_nx   = succ;
                     match_nx = 4'd1;
                     state_nx = S_ACQ;
                  end else begin
                     match_nx = 4'd0;
                     state_nx = S_SEARCH;
                  end
               end
            end
            default: begin
               if (legal) begin
                  exp_nx   = succ;
                  match_nx = 4'd1;
                  state_nx = (LOCK_N <= 4'd1) ? S_LOCKED : S_ACQ;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_SEARCH;
         exp_idx   <= 2'd0;
         match_cnt <= 4'd0;
         locked    <= 1'b0;
         phase     <= 2'd0;
         err_pulse <= 1'b0;
         invalid   <= 1'b0;
         err_cnt   <= '0;
         cyc_cnt   <= '0;
      end else begin
         state     <= state_nx;
         exp_idx   <= exp_nx;
         match_cnt <= match_nx;
         locked    <= (state_nx == S_LOCKED);
         err_pulse <= err_evt;
         invalid   <= sample_en && !legal;
         if (sample_en && legal) phase <= idx;
         // clr wins over a same-cycle increment
         if (clr) err_cnt <= '0;
         else if (err_evt && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
         if (clr) cyc_cnt <= '0;
         else if (cyc_evt) cyc_cnt <= cyc_cnt + CYC_W'(1);
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Bench for led_pattern_monitor: directed plan steps followed by random traffic,
// checked against a run-length model of the LED sequence.
module tb_led_pattern_monitor;

   localparam int LC    = 4;
   localparam int ERR_W = 2;
   localparam int CYC_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sample_en = 1'b0;
   logic [2:0]       led_in = 3'b000;
   logic             clr = 1'b0;
   logic             locked;
   logic [1:0]       phase;
   logic             err_pulse;
   logic             invalid;
   logic [ERR_W-1:0] err_cnt;
   logic [CYC_W-1:0] cyc_cnt;
   logic [1:0]       state_dbg;

   int tests = 0;
   int fails = 0;

   // model: run = length of the current unbroken chain of successive legal samples
   int run, last, m_phase, m_err, m_cyc;
   bit m_pulse, m_inv;

   led_pattern_monitor #(.LOCK_COUNT(LC), .ERR_W(ERR_W), .CYC_W(CYC_W)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .led_in(led_in), .clr(clr),
      .locked(locked), .phase(phase), .err_pulse(err_pulse), .invalid(invalid),
      .err_cnt(err_cnt), .cyc_cnt(cyc_cnt), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] pat_of(input int i);
      case (i % 4)
         0:       return 3'b001;
         1:       return 3'b010;
         2:       return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      run = 0; last = 0; m_phase = 0; m_err = 0; m_cyc = 0; m_pulse = 0; m_inv = 0;
   endtask

   task automatic model_update(input logic en, input logic [2:0] led, input logic c);
      int  idx;
      bit  legal, was_locked, match;
      m_pulse = 0;
      m_inv   = 0;
      if (en) begin
         legal = 1;
         idx   = 0;
         case (led)
            3'b001:  idx = 0;
            3'b010:  idx = 1;
            3'b100:  idx = 2;
            3'b000:  idx = 3;
            default: legal = 0;
         endcase
         was_locked = (run >= LC);
         match      = legal && (run > 0) && (idx == (last + 1) % 4);
         m_inv      = !legal;
         m_pulse    = was_locked && !match;
         if (m_pulse && m_err < (1 << ERR_W) - 1) m_err++;
         if (was_locked && match && idx == 0) m_cyc = (m_cyc + 1) % (1 << CYC_W);
         if (!legal) run = 0;
         else if (match) run = (run < LC) ? run + 1 : run;
         else run = 1;
         if (legal) begin
            last    = idx;
            m_phase = idx;
         end
      end
      if (c) begin
         m_err = 0;
         m_cyc = 0;
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".locked"}, 32'(locked), 32'(run >= LC));
      chk({ctx, ".phase"}, 32'(phase), 32'(m_phase));
      chk({ctx, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
      chk({ctx, ".invalid"}, 32'(invalid), 32'(m_inv));
      chk({ctx, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
      chk({ctx, ".cyc_cnt"}, 32'(cyc_cnt), 32'(m_cyc));
      chk({ctx, ".state"}, 32'(state_dbg), (run == 0) ? 32'd0 : (run < LC) ? 32'd1 : 32'd2);
   endtask

   // called at posedge+1; inputs settle well before the next edge
   task automatic step(input string ctx, input logic en, input logic [2:0] led, input logic c);
      sample_en = en;
      led_in    = led;
      clr       = c;
      @(posedge clk);
      #1;
      model_update(en, led, c);
      check_all(ctx);
   endtask

   task automatic drive_good(input string ctx);
      step(ctx, 1'b1, pat_of(last + 1), 1'b0);
   endtask

   task automatic lock_up(input string ctx);
      for (int k = 0; k < 8 && run < LC; k++) drive_good(ctx);
      chk({ctx, ".lock_reached"}, 32'(locked), 32'd1);
   endtask

   initial begin
      model_reset();

      // reset held with random activity
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sample_en = 1'($urandom_range(0, 1));
         led_in    = 3'($urandom_range(0, 7));
         clr       = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         check_all("in_reset");
      end
      rst = 1'b1;
      for (int i = 0; i < 10; i++) step("idle_after_reset", 1'b0, 3'($urandom_range(0, 7)), 1'b0);

      // lock acquisition
      step("acq", 1'b1, 3'b001, 1'b0);
      step("acq", 1'b1, 3'b010, 1'b0);
      step("acq", 1'b1, 3'b100, 1'b0);
      chk("acq.not_yet_locked", 32'(locked), 32'd0);
      step("acq", 1'b1, 3'b000, 1'b0);
      chk("acq.locked", 32'(locked), 32'd1);
      chk("acq.phase3", 32'(phase), 32'd3);
      for (int i = 0; i < 8; i++) drive_good("run8");
      chk("run8.cyc2", 32'(cyc_cnt), 32'd2);

      // sequence error: 100 where 010 is expected
      step("seq_err", 1'b1, 3'b001, 1'b0);
      step("seq_err", 1'b1, 3'b100, 1'b0);
      chk("seq_err.pulse", 32'(err_pulse), 32'd1);
      chk("seq_err.cnt1", 32'(err_cnt), 32'd1);
      chk("seq_err.unlocked", 32'(locked), 32'd0);
      chk("seq_err.phase2", 32'(phase), 32'd2);
      step("relock", 1'b1, 3'b000, 1'b0);
      chk("relock.pulse_gone", 32'(err_pulse), 32'd0);
      step("relock", 1'b1, 3'b001, 1'b0);
      step("relock", 1'b1, 3'b010, 1'b0);
      chk("relock.locked", 32'(locked), 32'd1);

      // illegal pattern while locked
      step("illegal", 1'b1, 3'b011, 1'b0);
      chk("illegal.invalid", 32'(invalid), 32'd1);
      chk("illegal.err_pulse", 32'(err_pulse), 32'd1);
      chk("illegal.phase_held", 32'(phase), 32'd1);
      chk("illegal.search", 32'(state_dbg), 32'd0);

      // stalled pattern while locked
      lock_up("stall_lock");
      while (((last + 1) % 4) != 0) drive_good("stall_align");
      step("stall", 1'b1, 3'b001, 1'b0);
      step("stall", 1'b1, 3'b001, 1'b0);
      chk("stall.err_pulse", 32'(err_pulse), 32'd1);
      chk("stall.cnt3", 32'(err_cnt), 32'd3);

      // saturation and clear
      step("clr", 1'b0, 3'b000, 1'b1);
      chk("clr.err0", 32'(err_cnt), 32'd0);
      for (int e = 0; e < 5; e++) begin
         lock_up("sat_lock");
         step("sat_err", 1'b1, pat_of(last), 1'b0);
      end
      chk("sat.cnt3", 32'(err_cnt), 32'd3);
      lock_up("sat_lock6");
      step("clr_err", 1'b1, pat_of(last), 1'b1);
      chk("clr_err.cnt0", 32'(err_cnt), 32'd0);
      chk("clr_err.pulse", 32'(err_pulse), 32'd1);

      // sparse strobe
      step("sparse_break", 1'b1, 3'b111, 1'b0);
      for (int s = 0; s < 4; s++) begin
         drive_good("sparse");
         if (s == 3) chk("sparse.locked", 32'(locked), 32'd1);
         step("sparse_idle", 1'b0, 3'($urandom_range(0, 7)), 1'b0);
         step("sparse_idle", 1'b0, 3'($urandom_range(0, 7)), 1'b0);
      end

      // asynchronous reset between edges
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("async_rst.locked", 32'(locked), 32'd0);
      check_all("async_rst");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_all("async_rst_hold");
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step("after_rst_idle", 1'b0, 3'($urandom_range(0, 7)), 1'b0);
      lock_up("after_rst");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         int       r;
         logic [2:0] led;
         r = int'($urandom_range(0, 99));
         if (r < 70) led = pat_of(last + 1);
         else if (r < 85) led = pat_of(int'($urandom_range(0, 3)));
         else led = 3'($urandom_range(0, 7));
         step("random", 1'($urandom_range(0, 3) != 0), led, 1'($urandom_range(0, 49) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/led_pattern_monitor.md
Name: led_pattern_monitor

Overview:
- Receive-side checker for the 3-bit one-hot LED sequencer pattern {LED2,LED1,LED0}, cycling 001 -> 010 -> 100 -> 000 -> 001.
- Samples the pattern on a strobe, locks to the sequence, then flags and counts sequence errors and completed cycles.
- Sits beside the LED sequencer for self-test, or on a board input to verify an external LED driver.

Parameters:
- LOCK_COUNT, 4: consecutive correct samples required to declare lock (1..15).
- ERR_W, 8: width of the error counter (saturating).
- CYC_W, 16: width of the completed-cycle counter (wrapping).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- sample_en  input  1  sample strobe; led_in is evaluated only in cycles where it is 1.
- led_in  input  3  observed pattern {LED2,LED1,LED0}, synchronous to clk.
- clr  input  1  synchronous clear of err_cnt and cyc_cnt only.
- locked  output  1  high while in LOCKED.
- phase  output  2  index of the last valid sample: 001=0, 010=1, 100=2, 000=3.
- err_pulse  output  1  one-cycle pulse on a sequence error while locked.
- invalid  output  1  one-cycle pulse when a sample is not one of the four legal patterns.
- err_cnt  output  ERR_W  saturating count of err_pulse events.
- cyc_cnt  output  CYC_W  wrapping count of completed cycles while locked.

Behaviour:
- Reset (rst=0, asynchronous): state=SEARCH, match_cnt=0, exp=0, every output 0.
- All outputs are registered and update on the edge that ends the sample_en cycle, so latency is 1 clk. With sample_en=0, all state and outputs hold, and the pulse outputs are 0.
- Legal patterns: 001, 010, 100, 000. Any other value (011, 101, 110, 111) is illegal: it raises invalid for 1 cycle and leaves phase unchanged.
- A legal sample updates phase to its index. The successor of index p is (p+1) mod 4.
- SEARCH:
  - legal sample: exp<=succ, match_cnt<=1, then go to ACQ. If LOCK_COUNT==1, go directly to LOCKED.
  - illegal sample: stay in SEARCH.
- ACQ:
  - sample equals exp: exp<=succ, match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED.
  - legal sample not equal to exp: restart acquisition from this sample (match_cnt<=1, exp<=succ, stay in ACQ). No err_pulse.
  - illegal sample: go to SEARCH, match_cnt<=0. No err_pulse.
- LOCKED:
  - sample equals exp: exp<=succ. If the sample is 001, cyc_cnt increments, wrapping at 2^CYC_W.
  - mismatch (legal or illegal): err_pulse=1 for one cycle, err_cnt increments and saturates at all-ones, locked falls on the same edge. Re-acquisition then proceeds exactly as the ACQ mismatch rules (a legal sample becomes the new reference).
- A repeated identical sample (pattern not advancing) counts as a mismatch.
- clr has priority over a simultaneous increment: both counters go to 0 and that increment is lost. clr does not affect state, locked, exp or phase.
- Reset mid-operation aborts immediately to the reset values. No pulse is emitted on reset release.
- match_cnt width is 4 bits. It is meaningful only in ACQ.

Test Plan:
- Reset check: hold rst=0 while driving random led_in and sample_en -> all outputs 0. Release rst with sample_en=0 for 10 cycles -> outputs stay 0.
- Lock acquisition (LOCK_COUNT=4, sample_en=1 every cycle):
  - drive 001, 010, 100, 000 -> locked=1 one cycle after the 000 sample, phase=3, err_cnt=0.
  - continue for 8 correct samples -> cyc_cnt=2.
- Sequence error while locked: drive 100 when 010 is expected -> err_pulse high for exactly 1 cycle, err_cnt=1, locked=0, phase=2. Then drive 000, 001, 010 -> locked=1 after the 4th consecutive match.
- Illegal pattern (a) and stalled pattern (b):
  - (a) while locked, drive 011 -> invalid=1 and err_pulse=1 in the same cycle, phase unchanged, state SEARCH.
  - (b) drive 001, 001 while locked -> one error.
- Saturation and clear (ERR_W=2):
  - inject 5 errors -> err_cnt=3.
  - assert clr in the same cycle as a 6th error -> err_cnt=0, err_pulse still pulses.
- Sparse strobe and async reset: sample_en every 3rd cycle with a correct sequence -> lock after 4 strobes, no change between strobes. Assert rst mid-cycle while locked -> locked drops immediately, without waiting for a clk edge.
